// File: rtl/seg_ctrl_param.sv
// seg_ctrl_param: sequences filler/data/CRC bits of each K-/K+ code block; define SEG_GAP_EN for GAP_CYC idle cycles between blocks.
// Latency: first wr_en 4 cycles after size_empty falls; END (plus GAP when enabled) separates blocks.
// Backpressure: out_ready=0 holds state and counters in FILL/DATA/CRC and gates wr_en, data_rd and crc_en.
module seg_ctrl_param #(
    parameter int K_PLUS  = 6144,
    parameter int K_MINUS = 1056,
    parameter int CRC_LEN = 24,
    parameter int CNT_W   = 16,
    parameter int NB_W    = 2,
    parameter int GAP_CYC = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    size_empty,
    input  logic [2*NB_W+CNT_W-1:0] size_in,
    output logic                    size_rd,
    input  logic                    data_empty,
    output logic                    data_rd,
    input  logic                    out_ready,
    output logic                    sel_fill,
    output logic                    sel_crc,
    output logic                    crc_init,
    output logic                    crc_en,
    output logic                    crc_nshift,
    output logic                    wr_en,
    output logic                    start,
    output logic                    block_size,
    output logic                    last,
    output logic [2*NB_W-1:0]       blk_idx,
    output logic                    err
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_LATCH, S_LOAD, S_FILL, S_DATA, S_CRC, S_END, S_GAP
    } state_t;

    typedef struct packed {
        logic [NB_W-1:0]  cp;
        logic [NB_W-1:0]  cm;
        logic [CNT_W-1:0] f;
    } desc_t;

    typedef struct packed {
        logic size_rd;
        logic sel_fill;
        logic sel_crc;
        logic crc_init;
        logic crc_idle;
        logic crc_nshift;
        logic start;
    } ctl_t;

    // Moore controls are registered from the state being entered.
    function automatic ctl_t decode(input state_t s);
        ctl_t c;
        c.size_rd    = (s == S_FETCH);
        c.sel_fill   = (s == S_DATA) || (s == S_CRC);
        c.sel_crc    = (s == S_CRC);
        c.crc_init   = (s == S_IDLE) || (s == S_END);
        c.crc_idle   = (s == S_IDLE);
        c.crc_nshift = (s == S_FILL) || (s == S_DATA);
        c.start      = (s == S_LOAD);
        return c;
    endfunction

    state_t           state;
    ctl_t             ctl;
    desc_t            d;
    logic [NB_W:0]    d_sum;
    logic [NB_W-1:0]  cp, cm;
    logic [CNT_W-1:0] f, cnt, cnt_dec, kcur, crc_l;
    logic             crc_req, primed, load_fill, cnt_one;
    logic             unused_data_empty;

    assign d                 = size_in;
    assign d_sum             = {1'b0, d.cp} + {1'b0, d.cm};
    assign kcur              = block_size ? CNT_W'(K_PLUS) : CNT_W'(K_MINUS);
    assign crc_l             = crc_req ? CNT_W'(CRC_LEN) : '0;
    assign cnt_one           = (cnt == CNT_W'(1));
    assign cnt_dec           = (cnt == '0) ? cnt : cnt - 1'b1;
    assign load_fill         = (f != '0) && (blk_idx == '0);
    assign unused_data_empty = data_empty;

    // A DATA bit may only leave once its FIFO read has been issued (primed).
    assign wr_en = out_ready && ((state == S_FILL) || (state == S_CRC) ||
                                 (state == S_DATA && primed));
    assign last  = wr_en && cnt_one && ((state == S_CRC) || (state == S_DATA && !crc_req));

    // Reads run one accepted bit ahead of the DATA bit they feed.
    always_comb begin
        data_rd = 1'b0;
        case (state)
            S_LOAD:  data_rd = out_ready && !load_fill;
            S_FILL:  data_rd = wr_en && cnt_one;
            S_DATA:  data_rd = out_ready && (!primed || (cnt > CNT_W'(1)));
            default: data_rd = 1'b0;
        endcase
    end

    assign size_rd    = ctl.size_rd;
    assign sel_fill   = ctl.sel_fill;
    assign sel_crc    = ctl.sel_crc;
    assign crc_init   = ctl.crc_init;
    assign crc_nshift = ctl.crc_nshift;
    assign start      = ctl.start;
    assign crc_en     = ctl.crc_idle || wr_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            ctl        <= '0;
            err        <= 1'b0;
            block_size <= 1'b0;
            blk_idx    <= '0;
            cp         <= '0;
            cm         <= '0;
            f          <= '0;
            cnt        <= '0;
            crc_req    <= 1'b0;
            primed     <= 1'b0;
        end else begin
            ctl    <= decode(state);
            err    <= 1'b0;
            primed <= data_rd || (primed && !(state == S_DATA && wr_en));
            case (state)
                S_IDLE: begin
                    if (!size_empty) begin
                        state <= S_FETCH;
                        ctl   <= decode(S_FETCH);
                    end
                end
                S_FETCH: begin
                    state <= S_LATCH;
                    ctl   <= decode(S_LATCH);
                end
                S_LATCH: begin
                    cp      <= d.cp;
                    cm      <= d.cm;
                    f       <= d.f;
                    crc_req <= (d_sum > (NB_W+1)'(1));
                    blk_idx <= '0;
                    if (d_sum == '0) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                        ctl   <= decode(S_IDLE);
                    end else begin
                        block_size <= (d.cm == '0);
                        state      <= S_LOAD;
                        ctl        <= decode(S_LOAD);
                    end
                end
                S_LOAD: begin
                    if (block_size) cp <= (cp == '0) ? cp : cp - 1'b1;
                    else            cm <= (cm == '0) ? cm : cm - 1'b1;
                    if (load_fill) begin
                        cnt   <= f;
                        state <= S_FILL;
                        ctl   <= decode(S_FILL);
                    end else begin
                        cnt   <= kcur - crc_l;
                        state <= S_DATA;
                        ctl   <= decode(S_DATA);
                    end
                end
                S_FILL: begin
                    if (wr_en) begin
                        if (cnt_one) begin
                            cnt   <= kcur - f - crc_l;
                            state <= S_DATA;
                            ctl   <= decode(S_DATA);
                        end else begin
                            cnt <= cnt_dec;
                        end
                    end
                end
                S_DATA: begin
                    if (wr_en) begin
                        if (cnt_one) begin
                            if (crc_req) begin
                                cnt   <= crc_l;
                                state <= S_CRC;
                                ctl   <= decode(S_CRC);
                            end else begin
                                state <= S_END;
                                ctl   <= decode(S_END);
                            end
                        end else begin
                            cnt <= cnt_dec;
                        end
                    end
                end
                S_CRC: begin
                    if (wr_en) begin
                        if (cnt_one) begin
                            state <= S_END;
                            ctl   <= decode(S_END);
                        end else begin
                            cnt <= cnt_dec;
                        end
                    end
                end
                S_END: begin
                    blk_idx <= blk_idx + 1'b1;
                    if ((cp != '0) || (cm != '0)) begin
`ifdef SEG_GAP_EN
                        cnt   <= CNT_W'(GAP_CYC);
                        state <= S_GAP;
                        ctl   <= decode(S_GAP);
`else
                        block_size <= (cm == '0);
                        state      <= S_LOAD;
                        ctl        <= decode(S_LOAD);
`endif
                    end else begin
                        state <= S_IDLE;
                        ctl   <= decode(S_IDLE);
                    end
                end
`ifdef SEG_GAP_EN
                S_GAP: begin
                    if (cnt <= CNT_W'(1)) begin
                        block_size <= (cm == '0);
                        state      <= S_LOAD;
                        ctl        <= decode(S_LOAD);
                    end else begin
                        cnt <= cnt_dec;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                    ctl   <= decode(S_IDLE);
                end
            endcase
        end
    end

`ifndef SEG_GAP_EN
    localparam int unused_gap_cyc = GAP_CYC;
`endif
endmodule
